iob_fp_align: RTL and testbench
===============================

IOB_FP_ALIGN -- requirements
Module: iob_fp_align

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning significand width including hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-003 SHALL have port clk_i  input  1  clock; single clock domain, all state on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port op_a_i  input  EXP_W+DATA_W  IEEE-style operand A: sign, biased exponent, DATA_W-1 fraction bits.
REQ-006 SHALL have port op_b_i  input  EXP_W+DATA_W  operand B, same format.
REQ-007 SHALL have port valid_i  input  1  operand pair valid.
REQ-008 SHALL have port ready_o  output  1  block accepts the pair this cycle.
REQ-009 SHALL have port valid_o  output  1  aligned result valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts the result.
REQ-011 SHALL have port sign_a_o, sign_b_o  output  1 each  signs of the swapped operands.
REQ-012 SHALL have port exponent_o  output  EXP_W  common (larger) effective exponent.
REQ-013 SHALL have port mantissa_a_o, mantissa_b_o  output  DATA_W+3 each  aligned significands with guard, round and sticky bits as LSBs.
REQ-014 SHALL have port swap_o  output  1  high when B was routed to the A lane.
REQ-015 SHALL have port nan_o, inf_o, zero_o  output  2 each  per-operand class flags, bit0 = original A, bit1 = original B.

Function
REQ-016 SHALL unpack each operand: exp==0 gives hidden bit 0 and effective exponent 1; otherwise hidden bit 1.
REQ-017 SHALL classify: exp all-ones with fraction nonzero = NaN, fraction zero = Inf; exp==0 with fraction zero = zero.
REQ-018 SHALL route the operand with the larger effective exponent to lane A; on equal exponents, original order is kept (swap_o=0).
REQ-019 SHALL form each significand as {hidden, fraction, 3'b000}, then right-shift lane B by d = expA-expB.
REQ-020 SHALL OR every bit shifted out below bit 0 into bit 0 (sticky).
REQ-021 SHALL, for d >= DATA_W+3, output lane B as all zeros except bit 0 = OR of the unshifted significand.
REQ-022 SHALL be a 2-stage pipeline: stage 1 registers unpack, classify, swap and d; stage 2 registers shift and sticky.
REQ-023 SHALL have latency 2 cycles from accepted valid_i to valid_o when ready_i is high.
REQ-024 SHALL accept one pair per cycle at full throughput.
REQ-025 SHALL transfer a pair on valid_i&&ready_o and a result on valid_o&&ready_i.
REQ-026 SHALL advance each stage when it is empty or its successor accepts: ready_o = ~v1 | ~v2 | ready_i.
REQ-027 SHALL hold valid_o and all result outputs stable while valid_o&&~ready_i.
REQ-028 SHALL pass class flags through unchanged; alignment of NaN/Inf operands is don't-care but deterministic.

Reset
REQ-029 SHALL, while rst_n_i is low at a clock edge, clear both stage valids, so that valid_o=0 and ready_o=1 on the next cycle.
REQ-030 SHALL reset all data outputs to 0.
REQ-031 SHALL discard in-flight pairs when reset is asserted mid-operation, with no output transfer.

Structure
REQ-032 SHALL take the exponent bias, field widths and class bit positions from shared package iob_fp_pkg.
REQ-033 SHALL instantiate sub-module iob_fp_unpack, combinational and once per operand, for field split, hidden bit and classification.
REQ-034 SHALL contain the shifter and sticky logic in this module.

Verification
REQ-035 SHALL verify: A=0x3F800000, B=0x3F800000 -> exponent_o=127, both mantissas 27'h4000000, swap_o=0, valid_o 2 cycles later.
REQ-036 SHALL verify: A=0x3F400000, B=0x3F800000 -> swap_o=1, exponent_o=127, mantissa_a_o=27'h4000000, mantissa_b_o=27'h3000000.
REQ-037 SHALL verify: A=0x3F800000, B=0x30800000 (d=30) -> mantissa_b_o=27'h0000001, mantissa_a_o=27'h4000000.
REQ-038 SHALL verify: back-to-back pairs with ready_i low 3 cycles -> ready_o low once both stages are full, outputs stable, no loss or duplication.
REQ-039 SHALL verify: A=0x7FC00000, B=0x00000000 -> nan_o=2'b01, zero_o=2'b10.
REQ-040 SHALL verify: rst_n_i low 1 cycle with 2 pairs in flight -> valid_o=0 next cycle, no stale result afterwards.

Source files
------------

// File: rtl/iob_fp_pkg.sv
// Shared floating-point definitions for the operand alignment datapath:
// default field widths, exponent bias, class-flag bit positions and the
// per-operand class record produced by the unpacker.
package iob_fp_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int DATA_W_DEF = 24;
    localparam int EXP_BIAS   = 127;

    // Guard, round and sticky bits appended below the significand
    localparam int GRS_W = 3;

    // Bit positions inside the 2-bit class flag outputs
    localparam int CLASS_A = 0;
    localparam int CLASS_B = 1;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    function automatic int aligned_w(input int data_w);
        return data_w + GRS_W;
    endfunction

endpackage

// File: rtl/iob_fp_unpack.sv
// Combinational operand unpacker: splits sign/exponent/fraction, restores
// the hidden bit, maps denormals to effective exponent 1 and classifies.
module iob_fp_unpack
    import iob_fp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic [EXP_W+DATA_W-1:0] op,
    output logic                    sign,
    output logic [EXP_W-1:0]        exp_eff,
    output logic [DATA_W-1:0]       sig,
    output fp_class_t               cls
);

    logic [EXP_W-1:0]  exp_raw;
    logic [DATA_W-2:0] frac;
    logic              exp_zero;
    logic              exp_ones;
    logic              frac_zero;

    assign sign      = op[EXP_W+DATA_W-1];
    assign exp_raw   = op[EXP_W+DATA_W-2 -: EXP_W];
    assign frac      = op[DATA_W-2:0];

    assign exp_zero  = (exp_raw == '0);
    assign exp_ones  = &exp_raw;
    assign frac_zero = (frac == '0);

    // Denormals share the scale of the smallest normal exponent
    assign exp_eff   = exp_zero ? EXP_W'(1) : exp_raw;
    assign sig       = {~exp_zero, frac};

    assign cls.nan   = exp_ones & ~frac_zero;
    assign cls.inf   = exp_ones & frac_zero;
    assign cls.zero  = exp_zero & frac_zero;

endmodule

// File: rtl/iob_fp_align.sv
// Two-stage floating-point operand aligner. Stage 1 unpacks, classifies,
// orders the operands by effective exponent and computes the exponent
// difference; stage 2 right-shifts the smaller operand with sticky capture.
// Valid/ready handshake on both sides, full throughput.
module iob_fp_align
    import iob_fp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [EXP_W+DATA_W-1:0] op_a_i,
    input  logic [EXP_W+DATA_W-1:0] op_b_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    sign_a_o,
    output logic                    sign_b_o,
    output logic [EXP_W-1:0]        exponent_o,
    output logic [DATA_W+2:0]       mantissa_a_o,
    output logic [DATA_W+2:0]       mantissa_b_o,
    output logic                    swap_o,
    output logic [1:0]              nan_o,
    output logic [1:0]              inf_o,
    output logic [1:0]              zero_o
);

    localparam int SW = aligned_w(DATA_W);

    logic              sign_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [DATA_W-1:0] sig_a;
    logic [DATA_W-1:0] sig_b;
    fp_class_t         cls_a;
    fp_class_t         cls_b;
    logic              swap_c;

    logic              v1;
    logic              s1_sign_a;
    logic              s1_sign_b;
    logic [EXP_W-1:0]  s1_exp;
    logic [EXP_W-1:0]  s1_d;
    logic [DATA_W-1:0] s1_sig_a;
    logic [DATA_W-1:0] s1_sig_b;
    logic              s1_swap;
    logic [1:0]        s1_nan;
    logic [1:0]        s1_inf;
    logic [1:0]        s1_zero;

    logic              adv1;
    logic              adv2;
    logic [SW-1:0]     full_b;
    logic [SW-1:0]     mant_b_c;

    iob_fp_unpack #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_unpack_a (
        .op      (op_a_i),
        .sign    (sign_a),
        .exp_eff (exp_a),
        .sig     (sig_a),
        .cls     (cls_a)
    );

    iob_fp_unpack #(.DATA_W(DATA_W), .EXP_W(EXP_W)) u_unpack_b (
        .op      (op_b_i),
        .sign    (sign_b),
        .exp_eff (exp_b),
        .sig     (sig_b),
        .cls     (cls_b)
    );

    // Equal exponents keep the original order
    assign swap_c  = (exp_b > exp_a);

    assign adv2    = ~valid_o | ready_i;
    assign adv1    = ~v1 | adv2;
    assign ready_o = adv1;

    assign full_b  = {s1_sig_b, {GRS_W{1'b0}}};

    // Lane B alignment: shifted-out bits collapse into the sticky LSB
    always_comb begin
        mant_b_c = '0;
        if (32'(s1_d) >= 32'(SW)) begin
            mant_b_c = {{(SW-1){1'b0}}, |s1_sig_b};
        end else begin
            mant_b_c = (full_b >> s1_d)
                     | {{(SW-1){1'b0}}, |(full_b & ~({SW{1'b1}} << s1_d))};
        end
    end

    // Stage 1: capture unpacked, ordered operands and exponent difference
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            v1        <= 1'b0;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_exp    <= '0;
            s1_d      <= '0;
            s1_sig_a  <= '0;
            s1_sig_b  <= '0;
            s1_swap   <= 1'b0;
            s1_nan    <= '0;
            s1_inf    <= '0;
            s1_zero   <= '0;
        end else if (adv1) begin
            v1 <= valid_i;
            if (valid_i) begin
                s1_sign_a <= swap_c ? sign_b : sign_a;
                s1_sign_b <= swap_c ? sign_a : sign_b;
                s1_exp    <= swap_c ? exp_b  : exp_a;
                s1_d      <= swap_c ? (exp_b - exp_a) : (exp_a - exp_b);
                s1_sig_a  <= swap_c ? sig_b  : sig_a;
                s1_sig_b  <= swap_c ? sig_a  : sig_b;
                s1_swap   <= swap_c;
                s1_nan[CLASS_A]  <= cls_a.nan;
                s1_nan[CLASS_B]  <= cls_b.nan;
                s1_inf[CLASS_A]  <= cls_a.inf;
                s1_inf[CLASS_B]  <= cls_b.inf;
                s1_zero[CLASS_A] <= cls_a.zero;
                s1_zero[CLASS_B] <= cls_b.zero;
            end
        end
    end

    // Stage 2: register aligned significands; held while downstream stalls
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            valid_o      <= 1'b0;
            sign_a_o     <= 1'b0;
            sign_b_o     <= 1'b0;
            exponent_o   <= '0;
            mantissa_a_o <= '0;
            mantissa_b_o <= '0;
            swap_o       <= 1'b0;
            nan_o        <= '0;
            inf_o        <= '0;
            zero_o       <= '0;
        end else if (adv2) begin
            valid_o <= v1;
            if (v1) begin
                sign_a_o     <= s1_sign_a;
                sign_b_o     <= s1_sign_b;
                exponent_o   <= s1_exp;
                mantissa_a_o <= {s1_sig_a, {GRS_W{1'b0}}};
                mantissa_b_o <= mant_b_c;
                swap_o       <= s1_swap;
                nan_o        <= s1_nan;
                inf_o        <= s1_inf;
                zero_o       <= s1_zero;
            end
        end
    end

endmodule

// File: tb/tb_iob_fp_align.sv
// Bench for iob_fp_align (single precision): directed alignment cases,
// backpressure, random stream against an arithmetic reference model, reset.
module tb_iob_fp_align;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        valid_i;
    logic        ready_o;
    logic        valid_o;
    logic        ready_i;
    logic        sign_a_o;
    logic        sign_b_o;
    logic [7:0]  exponent_o;
    logic [26:0] mantissa_a_o;
    logic [26:0] mantissa_b_o;
    logic        swap_o;
    logic [1:0]  nan_o;
    logic [1:0]  inf_o;
    logic [1:0]  zero_o;

    int checks = 0;
    int errors = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    bit rand_rdy = 1'b0;

    logic [70:0] exp_q[$];
    logic [70:0] mask_q[$];
    logic [70:0] got;
    logic [70:0] prev_out;
    logic        prev_stall = 1'b0;
    logic [70:0] mon_e;
    logic [70:0] mon_m;

    iob_fp_align dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .sign_a_o     (sign_a_o),
        .sign_b_o     (sign_b_o),
        .exponent_o   (exponent_o),
        .mantissa_a_o (mantissa_a_o),
        .mantissa_b_o (mantissa_b_o),
        .swap_o       (swap_o),
        .nan_o        (nan_o),
        .inf_o        (inf_o),
        .zero_o       (zero_o)
    );

    always #5 clk_i = ~clk_i;

    assign got = {sign_a_o, sign_b_o, exponent_o, mantissa_a_o, mantissa_b_o,
                  swap_o, nan_o, inf_o, zero_o};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: value-level alignment using integer arithmetic
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [70:0] e, output logic [70:0] m);
        int ea, eb, sa, sb, ehi, shi, slo, d, mb;
        logic sign_hi, sign_lo, swp;
        logic [1:0] nan, inf, zer;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan = {(eb == 255 && b[22:0] != 0), (ea == 255 && a[22:0] != 0)};
        inf = {(eb == 255 && b[22:0] == 0), (ea == 255 && a[22:0] == 0)};
        zer = {(eb == 0 && b[22:0] == 0), (ea == 0 && a[22:0] == 0)};
        sa = ((ea == 0) ? 0 : 8388608) + int'(a[22:0]);
        sb = ((eb == 0) ? 0 : 8388608) + int'(b[22:0]);
        sa = sa * 8;
        sb = sb * 8;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        swp = (eb > ea);
        if (swp) begin
            ehi = eb; shi = sb; slo = sa; d = eb - ea; sign_hi = b[31]; sign_lo = a[31];
        end else begin
            ehi = ea; shi = sa; slo = sb; d = ea - eb; sign_hi = a[31]; sign_lo = b[31];
        end
        if (d >= 27) begin
            mb = (slo != 0) ? 1 : 0;
        end else begin
            mb = slo / (1 << d);
            if ((slo % (1 << d)) != 0) mb = mb | 1;
        end
        e = {sign_hi, sign_lo, ehi[7:0], shi[26:0], mb[26:0], swp, nan, inf, zer};
        m = '1;
        if (nan != 2'b00 || inf != 2'b00) m[60:7] = '0;
    endfunction

    function automatic logic [31:0] rand_op(input int ref_exp);
        int k;
        int e;
        logic [22:0] f;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        if (k == 0) return {1'($urandom), 31'h0};
        if (k == 1) return {1'($urandom), 8'hFF, f};
        if (k == 2) return {1'($urandom), 8'h00, f};
        e = ref_exp + int'($urandom_range(0, 70)) - 35;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
        return {1'($urandom), e[7:0], f};
    endfunction

    // Scoreboard and hold-while-stalled monitor, sampled mid-cycle
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            exp_q.delete();
            mask_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", valid_o, 1);
                chk("hold_data", got, prev_out);
            end
            if (valid_i && ready_o) begin
                model(op_a_i, op_b_i, mon_e, mon_m);
                exp_q.push_back(mon_e);
                mask_q.push_back(mon_m);
                in_cnt++;
            end
            if (valid_o && ready_i) begin
                chk("out_has_expect", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    mon_m = mask_q.pop_front();
                    chk("result", got & mon_m, mon_e & mon_m);
                end
                out_cnt++;
            end
            prev_stall = valid_o && !ready_i;
            prev_out   = got;
        end
    end

    always @(posedge clk_i) begin
        #1;
        if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic drive_pair(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        logic acc = 1'b0;
        op_a_i  = a;
        op_b_i  = b;
        valid_i = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            #1;
            n++;
        end
        valid_i = 1'b0;
        chk("accept", acc, 1);
    endtask

    task automatic send_get(input logic [31:0] a, input logic [31:0] b);
        int lat = 0;
        op_a_i  = a;
        op_b_i  = b;
        valid_i = 1'b1;
        while (lat < 8) begin
            @(posedge clk_i);
            #1;
            lat++;
            valid_i = 1'b0;
            if (valid_o) break;
        end
        chk("latency", lat, 2);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        @(posedge clk_i);
        #1;
        chk("drain_empty", exp_q.size(), 0);
        chk("in_out_count", out_cnt, in_cnt);
    endtask

    initial begin
        int seen;
        int ref_exp;
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        op_a_i  = '0;
        op_b_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_ready_o", ready_o, 1);
        chk("rst_data", got, 0);

        send_get(32'h3F800000, 32'h3F800000);
        chk("eq_exponent", exponent_o, 127);
        chk("eq_mant_a", mantissa_a_o, 27'h4000000);
        chk("eq_mant_b", mantissa_b_o, 27'h4000000);
        chk("eq_swap", swap_o, 0);
        @(posedge clk_i); #1;

        send_get(32'h3F400000, 32'h3F800000);
        chk("sw_swap", swap_o, 1);
        chk("sw_exponent", exponent_o, 127);
        chk("sw_mant_a", mantissa_a_o, 27'h4000000);
        chk("sw_mant_b", mantissa_b_o, 27'h3000000);
        @(posedge clk_i); #1;

        send_get(32'h3F800000, 32'h30800000);
        chk("far_mant_a", mantissa_a_o, 27'h4000000);
        chk("far_mant_b", mantissa_b_o, 27'h0000001);
        chk("far_swap", swap_o, 0);
        @(posedge clk_i); #1;

        send_get(32'h7FC00000, 32'h00000000);
        chk("cls_nan", nan_o, 2'b01);
        chk("cls_zero", zero_o, 2'b10);
        chk("cls_inf", inf_o, 2'b00);
        @(posedge clk_i); #1;

        // Downstream stalls for three cycles under a back-to-back stream
        ready_i = 1'b0;
        fork
            begin
                drive_pair(32'h3F800000, 32'h3E000000);
                drive_pair(32'h40400000, 32'h41200000);
                drive_pair(32'hC2C80000, 32'h3C23D70A);
                drive_pair(32'h00400000, 32'h00000001);
            end
            begin
                repeat (2) @(posedge clk_i);
                #1;
                chk("bp_ready_low", ready_o, 0);
                @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            ref_exp = int'($urandom_range(1, 254));
            drive_pair(rand_op(ref_exp), rand_op(ref_exp));
        end
        rand_rdy = 1'b0;
        ready_i  = 1'b1;
        drain();

        // Reset with both stages occupied
        ready_i = 1'b0;
        drive_pair(32'h3F800000, 32'h40000000);
        drive_pair(32'h40800000, 32'h41000000);
        rst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        chk("mid_rst_valid_o", valid_o, 0);
        chk("mid_rst_ready_o", ready_o, 1);
        ready_i = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk_i);
            #1;
            if (valid_o) seen++;
        end
        chk("no_stale", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
